// File: rtl/reg_file_2r1w.sv
// 2-read / 1-write register file with a condition-flag bit and a write acknowledge.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read and flag forwarding.
module reg_file_2r1w #(
  parameter int IW       = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic [AW-1:0] i_RdAddrA,
  input  logic [AW-1:0] i_RdAddrB,
  output logic [IW-1:0] o_RdDataA,
  output logic [IW-1:0] o_RdDataB,
  input  logic          i_WrEn,
  input  logic [AW-1:0] i_WrAddr,
  input  logic [IW-1:0] i_WrData,
  input  logic          i_FlagWrEn,
  input  logic          i_FlagIn,
  output logic          o_Flag,
  output logic          o_WrAck
);

  localparam int DEPTH = 1 << AW;

  logic [IW-1:0] r_Regs [DEPTH];
  logic          r_Flag;
  logic          r_WrAck;
  logic          w_WrLive;
  logic [IW-1:0] w_StoredA;
  logic [IW-1:0] w_StoredB;

  // A write to the hardwired-zero register is acknowledged but never stored.
  assign w_WrLive = i_WrEn && !((ZERO_REG != 0) && (i_WrAddr == '0));

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        r_Regs[g] <= '0;
      end else if (w_WrLive && (i_WrAddr == AW'(g))) begin
        r_Regs[g] <= i_WrData;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Flag  <= 1'b0;
      r_WrAck <= 1'b0;
    end else begin
      if (i_FlagWrEn) begin
        r_Flag <= i_FlagIn;
      end
      r_WrAck <= i_WrEn;
    end
  end

  always_comb begin
    w_StoredA = r_Regs[i_RdAddrA];
    w_StoredB = r_Regs[i_RdAddrB];
    if ((ZERO_REG != 0) && (i_RdAddrA == '0)) w_StoredA = '0;
    if ((ZERO_REG != 0) && (i_RdAddrB == '0)) w_StoredB = '0;
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so outputs stay at their reset values.
  assign o_RdDataA = (!i_Reset && w_WrLive && (i_WrAddr == i_RdAddrA)) ? i_WrData : w_StoredA;
  assign o_RdDataB = (!i_Reset && w_WrLive && (i_WrAddr == i_RdAddrB)) ? i_WrData : w_StoredB;
  assign o_Flag    = (!i_Reset && i_FlagWrEn) ? i_FlagIn : r_Flag;
`else
  assign o_RdDataA = w_StoredA;
  assign o_RdDataB = w_StoredB;
  assign o_Flag    = r_Flag;
`endif

  assign o_WrAck = r_WrAck;

endmodule
